alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle issue stage that feeds the 8-bit ALU. It accepts register-based operations over a valid/ready handshake and buffers them in a 4-entry FIFO. It reads operands from an internal 8x8-bit register file, drives the ALU's control/operand inputs from registers, then captures the ALU result and zero flag one cycle later and writes the result back.

## Interface
- DEPTH, 4: operation FIFO entries; fixed at 4 (2-bit pointers, 3-bit count).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  FIFO can accept; equals count != 4.
- in_op  in  4  ALU control code, passed unmodified to alu_ctl.
- in_rd  in  3  destination register.
- in_rs  in  3  source A register.
- in_rt  in  3  source B register (ignored when in_imm_en=1).
- in_imm_en  in  1  B operand taken from in_imm.
- in_imm  in  8  immediate B operand.
- alu_ctl  out  4  to ALU control.
- alu_a  out  8  to ALU operand A.
- alu_b  out  8  to ALU operand B.
- alu_out  in  8  ALU result, combinational from alu_ctl/alu_a/alu_b.
- alu_zero  in  1  ALU zero flag.
- wb_valid  out  1  one-cycle pulse per completed operation.
- wb_rd  out  3  destination of completed operation.
- wb_data  out  8  result of completed operation.
- zero_flag  out  1  alu_zero of the most recent completed operation; held.
- busy  out  1  high when state != IDLE or FIFO non-empty.
- dbg_addr  in  3  register file read address.
- dbg_data  out  8  combinational read of regfile[dbg_addr]; r0 always reads 0.

## Operation
- FIFO entry: {op, rd, rs, rt, imm_en, imm} = 22 bits. Push on in_valid & in_ready. in_ready depends only on full, so no push occurs while full even if a pop happens in the same cycle.
- State machine: IDLE, ISSUE, EXEC.
  - IDLE: FIFO non-empty -> ISSUE; otherwise stay.
  - ISSUE: pop head. Register alu_ctl <= op, alu_a <= R[rs], alu_b <= imm_en ? imm : R[rt]. Go to EXEC.
  - EXEC: ALU output settles. At the closing edge: R[rd] <= alu_out (suppressed for rd=0), wb_valid <= 1, wb_rd <= rd, wb_data <= alu_out, zero_flag <= alu_zero. Next state is ISSUE if the FIFO is non-empty after the ISSUE pop, otherwise IDLE.
- wb_valid is high for exactly one cycle per operation. wb_data and wb_rd hold their values until the next completion.
- Register file: r0 reads 0 and writes to it are discarded. wb_valid and wb_data still report alu_out for rd=0.
- Undefined op codes are forwarded unmodified. The result is whatever the ALU returns (0 for undefined codes).
- No forwarding logic is needed. The write-back at the end of EXEC precedes the next ISSUE read.
- alu_ctl, alu_a and alu_b hold their last values outside ISSUE/EXEC.

## Timing
- Reset (async, rst_n=0): state=IDLE, FIFO count=0, pointers=0, all R[i]=0, alu_ctl/alu_a/alu_b=0, wb_valid=0, wb_rd=0, wb_data=0, zero_flag=0. Consequently in_ready=1 and busy=0. Reset mid-operation discards the in-flight op and flushes the FIFO; no wb_valid pulse follows.
- Latency: op accepted at edge E0 into an empty, idle unit -> ISSUE during E1–E2 -> ALU inputs valid after E2 -> write-back and wb_valid=1 after E3, for one cycle.
- Throughput: one op per 2 cycles while the FIFO is non-empty.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- Pointers wrap modulo 4.

## Test plan
- Reset: pulse rst_n low mid-cycle -> immediately in_ready=1, busy=0, wb_valid=0, alu_* = 0, dbg_data=0 for all addresses.
- Immediate load and subtract: ADD(2) r1=r0+imm5, then ADD r2=r0+imm3, then SUB(6) r3=r1-r2 -> three wb_valid pulses with wb_data 5, 3, 2; zero_flag=0; dbg r3=2. The first pulse comes 3 edges after acceptance.
- Zero and compare: SUB r4=r1-r1 -> wb_data=0, zero_flag=1. Then SLT(7) r5=r2<r1 -> wb_data=1, zero_flag=0. Then NOR(12) r6=~(r0|r0) -> 0xFF.
- Backpressure: in_valid held high with 7 ops from E0. Accepts occur at E0–E5 and count reaches 4 after E5. in_ready=0 until the E6 pop. The 7th op is accepted at E7. All 7 results appear in order, one per 2 cycles, with no loss or duplication.
- r0 protection and undefined op: ADD r0=r0+imm9 -> wb_valid with wb_rd=0, wb_data=9, dbg r0=0. Then op 5, r1=r0+imm7 -> wb_data=0 and zero_flag=1, given the ALU default.
- Reset mid-op: queue 3 ops, assert rst_n during the first EXEC -> no further wb_valid, count=0, all registers 0. A new op after release completes normally with 3-edge latency.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit ALU: a 4-deep op FIFO feeds a 3-state issue/exec FSM.
// Operands come from an 8x8 register file, and results are written back after one EXEC cycle.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [2:0] in_rd,
  input  logic [2:0] in_rs,
  input  logic [2:0] in_rt,
  input  logic       in_imm_en,
  input  logic [7:0] in_imm,
  output logic [3:0] alu_ctl,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic       wb_valid,
  output logic [2:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       zero_flag,
  output logic       busy,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       imm_en;
    logic [7:0] imm;
  } op_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, EXEC = 2'd2} state_t;

  state_t          state, state_nxt;
  op_t             fifo [DEPTH];
  op_t             ent, head;
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      count;
  logic            push, pop;
  logic [7:0][7:0] rf;
  logic [2:0]      ex_rd;

  assign in_ready = (count != 3'(DEPTH));
  assign push     = in_valid && in_ready;
  assign ent      = {in_op, in_rd, in_rs, in_rt, in_imm_en, in_imm};
  assign head     = fifo[rd_ptr];
  assign busy     = (state != IDLE) || (count != 3'd0);
  assign dbg_data = (dbg_addr == 3'd0) ? 8'h00 : rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // EXEC looks at the post-pop count; a push landing in the same cycle is picked up via IDLE.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:    if (count != 3'd0) state_nxt = ISSUE;
      ISSUE: begin
        pop       = 1'b1;
        state_nxt = EXEC;
      end
      EXEC:    state_nxt = (count != 3'd0) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Entry storage needs no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctl   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      ex_rd     <= '0;
      rf        <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      zero_flag <= 1'b0;
    end else begin
      wb_valid <= (state == EXEC);
      if (state == ISSUE) begin
        alu_ctl <= head.op;
        alu_a   <= rf[head.rs];
        alu_b   <= head.imm_en ? head.imm : rf[head.rt];
        ex_rd   <= head.rd;
      end
      if (state == EXEC) begin
        if (ex_rd != 3'd0) rf[ex_rd] <= alu_out;
        wb_rd     <= ex_rd;
        wb_data   <= alu_out;
        zero_flag <= alu_zero;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small reference ALU attached to its outputs.
// Write-backs are logged with their cycle numbers, then checked against hand-computed values.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [3:0] in_op = '0;
  logic [2:0] in_rd = '0, in_rs = '0, in_rt = '0;
  logic       in_imm_en = 1'b0;
  logic [7:0] in_imm = '0;
  logic [3:0] alu_ctl;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       alu_zero;
  logic       wb_valid, zero_flag, busy;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [2:0] rd;
    logic [7:0] data;
    logic       z;
  } wb_t;
  wb_t wbq[$];

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .zero_flag(zero_flag),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: 2=ADD 6=SUB 7=SLT 12=NOR 0=AND 1=OR; anything else returns 0.
  always_comb begin
    alu_out = 8'h00;
    case (alu_ctl)
      4'd0:  alu_out = alu_a & alu_b;
      4'd1:  alu_out = alu_a | alu_b;
      4'd2:  alu_out = alu_a + alu_b;
      4'd6:  alu_out = alu_a - alu_b;
      4'd7:  alu_out = (alu_a < alu_b) ? 8'd1 : 8'd0;
      4'd12: alu_out = ~(alu_a | alu_b);
      default: alu_out = 8'h00;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  always begin
    @(posedge clk);
    #1;
    if (wb_valid === 1'b1) wbq.push_back('{cyc, wb_rd, wb_data, zero_flag});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, input logic ie, input logic [7:0] imm,
                      output int acc);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_imm_en = ie; in_imm = imm;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  // Waits for n logged results, then a few more cycles so duplicate pulses would show up.
  task automatic wait_wb(input int n);
    int t;
    t = 0;
    while (wbq.size() < n && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("wb_count", 32'(wbq.size()), 32'(n));
  endtask

  task automatic chk_wb(input string tag, input logic [2:0] rd, input logic [7:0] d,
                        input logic z, input int ecyc);
    logic [11:0] got;
    int          gcyc;
    got  = 12'hfff;
    gcyc = -1;
    if (wbq.size() != 0) begin
      got  = {wbq[0].rd, wbq[0].data, wbq[0].z};
      gcyc = wbq[0].cyc;
      wbq.delete(0);
    end
    chk(tag, 32'(got), 32'({rd, d, z}));
    if (ecyc >= 0) chk({tag, "_cyc"}, 32'(gcyc), 32'(ecyc));
  endtask

  task automatic chk_dbg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_wbv"},   32'(wb_valid), 32'd0);
    chk({tag, "_alu"},   32'({alu_ctl, alu_a, alu_b}), 32'd0);
    for (int i = 0; i < 8; i++) chk_dbg({tag, "_rf"}, 3'(i), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a;
    int acc [7];
    int exp_off [7];
    exp_off = '{0, 1, 2, 3, 4, 5, 7};

    // Reset asserted mid-cycle must take effect without a clock edge.
    #3 rst_n = 1'b0;
    #1 chk_reset_state("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Immediate loads then subtract.
    send(4'd2, 3'd1, 3'd0, 3'd0, 1'b1, 8'd5, c0);
    send(4'd2, 3'd2, 3'd0, 3'd0, 1'b1, 8'd3, a);
    send(4'd6, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, a);
    wait_wb(3);
    chk_wb("add_r1", 3'd1, 8'd5, 1'b0, c0 + 3);
    chk_wb("add_r2", 3'd2, 8'd3, 1'b0, -1);
    chk_wb("sub_r3", 3'd3, 8'd2, 1'b0, -1);
    chk("zero_flag_sub", 32'(zero_flag), 32'd0);
    chk_dbg("dbg_r3", 3'd3, 8'd2);

    // Zero result, compare, NOR.
    send(4'd6,  3'd4, 3'd1, 3'd1, 1'b0, 8'd0, a);
    send(4'd7,  3'd5, 3'd2, 3'd1, 1'b0, 8'd0, a);
    send(4'd12, 3'd6, 3'd0, 3'd0, 1'b0, 8'd0, a);
    wait_wb(3);
    chk_wb("sub_zero", 3'd4, 8'h00, 1'b1, -1);
    chk_wb("slt_r5",   3'd5, 8'h01, 1'b0, -1);
    chk_wb("nor_r6",   3'd6, 8'hff, 1'b0, -1);
    chk_dbg("dbg_r6", 3'd6, 8'hff);

    // Backpressure: seven back-to-back ops; the seventh stalls until after the E6 pop.
    for (int k = 0; k < 7; k++) send(4'd2, 3'(k + 1), 3'd0, 3'd0, 1'b1, 8'(8'h10 + k), acc[k]);
    for (int k = 0; k < 7; k++) chk("bp_accept", 32'(acc[k] - acc[0]), 32'(exp_off[k]));
    wait_wb(7);
    for (int k = 0; k < 7; k++)
      chk_wb("bp_wb", 3'(k + 1), 8'(8'h10 + k), 1'b0, acc[0] + 3 + 2 * k);
    chk_dbg("dbg_r7_bp", 3'd7, 8'h16);

    // r0 write is discarded; an undefined op yields 0 from the ALU.
    send(4'd2, 3'd0, 3'd0, 3'd0, 1'b1, 8'd9, a);
    send(4'd5, 3'd1, 3'd0, 3'd0, 1'b1, 8'd7, a);
    wait_wb(2);
    chk_wb("r0_wb", 3'd0, 8'd9, 1'b0, -1);
    chk_wb("undef_op", 3'd1, 8'd0, 1'b1, -1);
    chk_dbg("dbg_r0", 3'd0, 8'h00);
    chk_dbg("dbg_r1_undef", 3'd1, 8'h00);

    // Reset during the first EXEC flushes everything.
    send(4'd2, 3'd1, 3'd0, 3'd0, 1'b1, 8'd1, a);
    send(4'd2, 3'd2, 3'd0, 3'd0, 1'b1, 8'd2, a);
    send(4'd2, 3'd3, 3'd0, 3'd0, 1'b1, 8'd3, a);
    rst_n = 1'b0;
    #1 chk_reset_state("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midop_no_wb", 32'(wbq.size()), 32'd0);
    send(4'd2, 3'd7, 3'd0, 3'd0, 1'b1, 8'd42, c0);
    wait_wb(1);
    chk_wb("post_reset", 3'd7, 8'd42, 1'b0, c0 + 3);
    chk_dbg("dbg_r7_post", 3'd7, 8'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
